// File: rtl/encoder_proj.sv
// encoder_proj -- serial Manchester frame encoder.
//
// Accepts one byte per valid/ready handshake and sends it as a frame:
//   START : one Manchester '1' (low then high), which gives a falling edge out of idle
//   DATA  : 8 bits, LSB first
//   PARITY: one even-parity bit (only when ENCODER_PARITY_EN is defined)
//   STOP  : line held high for two half-bits; done_out pulses on its last cycle
// Encoding: the first half-bit is ~b and the second half-bit is b. Each half-bit
// lasts HALF_CYCLES clocks.
//
// Configuration macro: ENCODER_PARITY_EN. When it is undefined, DATA goes directly
// to STOP and no parity logic is built.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous, active-high reset
//   data_in    byte to transmit, sampled only on handshake
//   valid_in   data_in holds a byte to send
//   ready_out  block can accept a byte this cycle (IDLE only)
//   tx_out     Manchester serial line, idle high
//   busy_out   frame in progress
//   done_out   one-cycle pulse on the final cycle of a frame
module encoder_proj #(
    parameter int HALF_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       tx_out,
    output logic       busy_out,
    output logic       done_out
);

    localparam int            CW      = $clog2(HALF_CYCLES + 1);
    localparam logic [CW-1:0] HC_LAST = CW'(HALF_CYCLES - 1);

`ifdef ENCODER_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state, state_n;
    logic          half, half_n;       // 0 = first half-bit, 1 = second half-bit
    logic [CW-1:0] cnt, cnt_n;         // cycles left in the current half-bit
    logic [2:0]    bit_cnt, bit_n;
    logic [7:0]    shreg, shreg_n;     // bit 0 is the data bit currently on the line
    logic          tx_n, done_n;
`ifdef ENCODER_PARITY_EN
    logic          par, par_n;
`endif

    always_comb begin
        state_n = state;
        half_n  = half;
        cnt_n   = cnt;
        bit_n   = bit_cnt;
        shreg_n = shreg;
`ifdef ENCODER_PARITY_EN
        par_n   = par;
`endif
        tx_n    = 1'b1;

        case (state)
            IDLE: begin
                if (valid_in && ready_out) begin
                    state_n = START;
                    half_n  = 1'b0;
                    cnt_n   = HC_LAST;
                    bit_n   = 3'd0;
                    shreg_n = data_in;
`ifdef ENCODER_PARITY_EN
                    par_n   = ^data_in;
`endif
                end
            end
            default: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    // Half-bit boundary: reload the counter and advance.
                    cnt_n = HC_LAST;
                    if (!half) begin
                        half_n = 1'b1;
                    end else begin
                        half_n = 1'b0;
                        case (state)
                            START: begin
                                state_n = DATA;
                                bit_n   = 3'd0;
                            end
                            DATA: begin
                                // The last bit ends at count 7; the counter is not wrapped.
                                if (bit_cnt == 3'd7) begin
`ifdef ENCODER_PARITY_EN
                                    state_n = PARITY;
`else
                                    state_n = STOP;
`endif
                                end else begin
                                    bit_n   = bit_cnt + 3'd1;
                                    shreg_n = shreg >> 1;
                                end
                            end
`ifdef ENCODER_PARITY_EN
                            PARITY:  state_n = STOP;
`endif
                            default: state_n = IDLE;  // end of STOP
                        endcase
                    end
                end
            end
        endcase

        // Outputs are registered, so they are derived from the next state.
        case (state_n)
            START:   tx_n = half_n;
            DATA:    tx_n = half_n ? shreg_n[0] : ~shreg_n[0];
`ifdef ENCODER_PARITY_EN
            PARITY:  tx_n = half_n ? par_n : ~par_n;
`endif
            default: tx_n = 1'b1;
        endcase

        done_n = (state_n == STOP) && half_n && (cnt_n == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            half      <= 1'b0;
            cnt       <= '0;
            bit_cnt   <= 3'd0;
            shreg     <= 8'd0;
`ifdef ENCODER_PARITY_EN
            par       <= 1'b0;
`endif
            tx_out    <= 1'b1;
            ready_out <= 1'b0;
            busy_out  <= 1'b0;
            done_out  <= 1'b0;
        end else begin
            state     <= state_n;
            half      <= half_n;
            cnt       <= cnt_n;
            bit_cnt   <= bit_n;
            shreg     <= shreg_n;
`ifdef ENCODER_PARITY_EN
            par       <= par_n;
`endif
            tx_out    <= tx_n;
            ready_out <= (state_n == IDLE);
            busy_out  <= (state_n != IDLE);
            done_out  <= done_n;
        end
    end

endmodule

// File: tb/tb_encoder_proj.sv
// Testbench for encoder_proj (HALF_CYCLES = 2). A waveform-level reference model
// expands each accepted byte into its list of half-bit levels and checks every
// output on every cycle. Directed frames are also compared against hand-written
// half-bit strings.
module tb_encoder_proj;

    localparam int HC = 2;
`ifdef ENCODER_PARITY_EN
    localparam int          NH   = 22;
    localparam logic [21:0] A5_H = 22'b0101100110100110011011;
    localparam logic [21:0] H01  = 22'b0101101010101010100111;
    localparam logic [21:0] H3C  = 22'b0110100101010110101011;
`else
    localparam int          NH   = 20;
    localparam logic [21:0] A5_H = 22'b01011001101001100111;
    localparam logic [21:0] H01  = 22'b01011010101010101011;
    localparam logic [21:0] H3C  = 22'b01101001010101101011;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_in = 1'b0;
    logic [7:0] data_in = 8'd0;
    logic       ready_out, tx_out, busy_out, done_out;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    encoder_proj #(.HALF_CYCLES(HC)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .tx_out    (tx_out),
        .busy_out  (busy_out),
        .done_out  (done_out)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Half-bit levels of a frame, right-aligned; half h is v[n-1-h].
    function automatic void mk_halves(input logic [7:0] d, output logic [21:0] v, output int n);
        int   nb;
        logic b;
        v  = '0;
        n  = 0;
        nb = 9;
`ifdef ENCODER_PARITY_EN
        nb = 10;
`endif
        for (int i = 0; i < nb; i++) begin
            b = (i == 0) ? 1'b1 : (i <= 8) ? d[i-1] : ^d;
            v[21-n] = ~b; n++;
            v[21-n] = b;  n++;
        end
        v[21-n] = 1'b1; n++;
        v[21-n] = 1'b1; n++;
        v = v >> (22 - n);
    endfunction

    // Reference model: frame position 0 = idle, 1..mlen = cycles of the frame.
    logic [21:0] mv;
    int          mn, mpos, mlen;
    logic        m_tx, m_rdy, m_busy, m_done;
    bit          m_ok = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            mpos = 0;
            m_tx = 1'b1; m_rdy = 1'b0; m_busy = 1'b0; m_done = 1'b0;
            m_ok = 1'b1;
        end else if (m_ok) begin
            if (mpos == 0) begin
                if (valid_in && m_rdy) begin
                    mk_halves(data_in, mv, mn);
                    mlen = mn * HC;
                    mpos = 1;
                end
            end else if (mpos == mlen) begin
                mpos = 0;
            end else begin
                mpos++;
            end
            if (mpos == 0) begin
                m_tx = 1'b1; m_rdy = 1'b1; m_busy = 1'b0; m_done = 1'b0;
            end else begin
                m_tx   = mv[mn - 1 - (mpos - 1) / HC];
                m_rdy  = 1'b0;
                m_busy = 1'b1;
                m_done = (mpos == mlen);
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("cyc_tx", tx_out, m_tx);
            chk("cyc_ready", ready_out, m_rdy);
            chk("cyc_busy", busy_out, m_busy);
            chk("cyc_done", done_out, m_done);
        end
    end

    task automatic wait_ready();
        int k = 0;
        while (!m_rdy && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (!m_rdy) chk("wait_ready_timeout", 0, 1);
    endtask

    // Send one byte and compare the whole frame with a literal half-bit string.
    task automatic directed(input logic [7:0] d, input logic [21:0] exp_h, input string nm);
        int done_at = -1;
        int rdy_at = -1;
        int bad = 0;
        wait_ready();
        valid_in = 1'b1;
        data_in  = d;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        for (int i = 1; i <= NH * HC + 1; i++) begin
            if (i > 1) @(negedge clk);
            data_in = 8'($urandom);
            if (i <= NH * HC && tx_out !== exp_h[NH - 1 - (i - 1) / HC]) bad++;
            if (done_out === 1'b1 && done_at < 0) done_at = i;
            if (ready_out === 1'b1 && rdy_at < 0) rdy_at = i;
        end
        chk({nm, "_wave_errs"}, bad, 0);
        chk({nm, "_done_cycle"}, done_at, NH * HC);
        chk({nm, "_ready_cycle"}, rdy_at, NH * HC + 1);
    endtask

    initial begin
        logic [21:0] v;
        int n, k, bad;

        // Pin the model against hand-derived frames.
        mk_halves(8'hA5, v, n);
        chk("model_a5_halves", v, A5_H);
        chk("model_len", n, NH);
        mk_halves(8'h3C, v, n);
        chk("model_3c_halves", v, H3C);
        mk_halves(8'h01, v, n);
        chk("model_01_halves", v, H01);

        // Reset for 3 cycles, then release.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx_out, 1);
        chk("rst_ready", ready_out, 0);
        chk("rst_busy", busy_out, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_tx", tx_out, 1);
        chk("post_rst_ready", ready_out, 1);
        chk("post_rst_busy", busy_out, 0);
        chk("post_rst_done", done_out, 0);

        directed(8'hA5, A5_H, "a5");
        directed(8'h01, H01, "x01");

        // Back-to-back frames with valid_in held: 0x00 then 0xFF.
        wait_ready();
        valid_in = 1'b1;
        data_in  = 8'h00;
        @(negedge clk);
        data_in = 8'hFF;
        k = 0;
        while (done_out !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("b2b_first_done", done_out, 1);
        @(negedge clk);
        chk("b2b_ready_after_done", ready_out, 1);
        @(negedge clk);
        chk("b2b_second_busy", busy_out, 1);
        chk("b2b_second_start_low", tx_out, 0);
        valid_in = 1'b0;
        bad = 0;
        for (int i = 2; i <= NH * HC; i++) begin
            @(negedge clk);
            data_in = 8'($urandom);
            if ((i - 1) / HC >= 2 && (i - 1) / HC <= 17 && tx_out !== 1'((i - 1) / HC % 2)) bad++;
        end
        chk("b2b_ff_data_errs", bad, 0);
        chk("b2b_second_done", done_out, 1);

        // Reset at cycle 10 of a 0x3C frame.
        wait_ready();
        valid_in = 1'b1;
        data_in  = 8'h3C;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_tx", tx_out, 1);
        chk("abort_done", done_out, 0);
        chk("abort_busy", busy_out, 0);
        chk("abort_ready", ready_out, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready_after", ready_out, 1);
        directed(8'h3C, H3C, "x3c");

        // Reset coincident with a handshake must win.
        wait_ready();
        rst      = 1'b1;
        valid_in = 1'b1;
        data_in  = 8'h5A;
        @(negedge clk);
        rst      = 1'b0;
        valid_in = 1'b0;
        chk("rst_hs_busy", busy_out, 0);
        @(negedge clk);
        chk("rst_hs_busy2", busy_out, 0);
        chk("rst_hs_ready", ready_out, 1);

        // Random traffic, including valid pulses while busy and rare resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            valid_in = ($urandom_range(0, 3) == 0);
            data_in  = 8'($urandom);
            rst      = ($urandom_range(0, 299) == 0);
        end
        rst      = 1'b0;
        valid_in = 1'b0;
        wait_ready();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/encoder_proj.md
ENCODER_PROJ -- requirements
Module: encoder_proj

Interface
REQ-001 Parameter HALF_CYCLES, default 4, meaning clock cycles per Manchester half-bit; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 data_in  input  8  byte to transmit; sampled only on handshake.
REQ-005 valid_in  input  1  data_in holds a byte to send.
REQ-006 ready_out  output  1  block can accept a byte this cycle.
REQ-007 tx_out  output  1  serial Manchester line; idle level high.
REQ-008 busy_out  output  1  frame in progress (any state other than IDLE).
REQ-009 done_out  output  1  one-cycle pulse on final cycle of a frame.

Function
REQ-010 States SHALL be IDLE, START, DATA, PARITY, STOP; tx_out, ready_out, busy_out and done_out SHALL be registered outputs.
REQ-011 ready_out SHALL be 1 only in IDLE; handshake = valid_in & ready_out at a rising edge.
REQ-012 On handshake, data_in SHALL be latched into a shift register and the state SHALL move to START; tx_out SHALL show the first START half-bit from the next cycle.
REQ-013 valid_in without ready_out SHALL be ignored; data_in changes after handshake SHALL not affect the frame in flight.
REQ-014 Bit encoding: first half-bit = ~b, second half-bit = b (0 -> high,low; 1 -> low,high); each half-bit lasts exactly HALF_CYCLES cycles.
REQ-015 START SHALL send one Manchester '1' (low, high), giving a falling edge out of idle.
REQ-016 DATA SHALL send 8 bits LSB first, tracked by a 3-bit bit counter that ends at 7 without wrapping into a ninth bit.
REQ-017 PARITY state SHALL exist only as in REQ-027/REQ-028.
REQ-018 STOP SHALL hold tx_out high for 2*HALF_CYCLES cycles; done_out SHALL be 1 in the last STOP cycle only.
REQ-019 After STOP the state SHALL return to IDLE; ready_out SHALL rise the cycle after done_out, so back-to-back frames are separated by one or more idle-high cycles.
REQ-020 The half-bit counter SHALL be sized as ceil(log2(HALF_CYCLES+1)) bits, reload at every half-bit boundary, and never wrap mid-half-bit.
REQ-021 Frame length from the first START cycle to done_out inclusive SHALL be (9+P)*2*HALF_CYCLES + 2*HALF_CYCLES cycles, P = 1 if parity compiled in, else 0.

Reset
REQ-022 While rst = 1: state IDLE, tx_out = 1, ready_out = 0, busy_out = 0, done_out = 0, counters and shift register cleared.
REQ-023 First cycle after rst deasserts, ready_out SHALL be 1.
REQ-024 Reset mid-frame SHALL abort the frame: tx_out high on the next edge, no done_out pulse, latched byte discarded.
REQ-025 rst coincident with a handshake SHALL win; the byte SHALL not be accepted.

Configuration
REQ-026 Macro ENCODER_PARITY_EN selects the parity feature.
REQ-027 With ENCODER_PARITY_EN defined: a PARITY state after DATA SHALL send one Manchester bit equal to the XOR of the 8 data bits (even parity).
REQ-028 Without ENCODER_PARITY_EN: DATA SHALL go directly to STOP; no parity logic is synthesized.

Verification (HALF_CYCLES = 2)
REQ-029 Reset 3 cycles then release -> tx_out = 1, ready_out = 1, busy_out = 0, done_out = 0 on the first post-reset cycle.
REQ-030 Send 0xA5, parity off -> half-bit sequence 01 01 10 01 10 10 01 10 01 11, each held 2 cycles; done_out high on cycle 40 after handshake; ready_out high on cycle 41.
REQ-031 Send 0xA5, ENCODER_PARITY_EN -> parity half-bits 10 inserted before stop; done_out on cycle 44. Send 0x01 -> parity half-bits 01.
REQ-032 Hold valid_in = 1 with 0x00 then 0xFF queued -> second handshake exactly one cycle after first done_out; 0xFF data half-bits all 01; data_in toggling mid-frame does not alter tx_out.
REQ-033 Assert rst at cycle 10 of a 0x3C frame -> tx_out = 1 next cycle, no done_out, ready_out = 1 the cycle after rst falls; a fresh 0x3C frame then matches the reference waveform.
REQ-034 valid_in pulsed while busy_out = 1 -> ignored; no extra frame transmitted.
